// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit (and future receive) engines.
// The break states exist only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  localparam int   UART_MIN_DATA_BITS = 5;
  localparam logic UART_IDLE_LEVEL    = 1'b1;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10,
    PAR_MARK = 2'b11
  } parity_e;

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BREAK,
    BREAK_MARK
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable baud down-counter: bit_end_o is high on the last clock of a bit
// period (count == 0). Shared between the TX engine and the future RX engine.
module uart_baud_cnt #(
  parameter int P_DIV_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic [P_DIV_WIDTH-1:0] load_val_i,
  output logic                   bit_end_o
);

  logic [P_DIV_WIDTH-1:0] cnt_q;
  logic [P_DIV_WIDTH-1:0] cnt_d;

  // Counting stops at zero, so a full-scale divisor can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - P_DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// Parametrised UART transmitter: 5..P_MAX_DATA_BITS data bits, none/odd/even/mark
// parity, 1/2 stop bits, runtime baud divisor, CTS flow control. UART_TX_BREAK_EN adds cfg_break.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int P_MAX_DATA_BITS   = 8,
  parameter int P_DIV_WIDTH       = 16,
  parameter int P_CTS_SYNC_STAGES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [P_DIV_WIDTH-1:0]     cfg_baud_div,
  input  logic [4:0]                 cfg_data_bits,
  input  logic [1:0]                 cfg_parity,
  input  logic                       cfg_two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                       cfg_break,
`endif
  input  logic [P_MAX_DATA_BITS-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       CTS,
  output logic                       TxD,
  output logic                       busy,
  output logic                       frame_done
);

  function automatic logic [4:0] clamp_bits(input logic [4:0] req);
    if (req < 5'(UART_MIN_DATA_BITS)) return 5'(UART_MIN_DATA_BITS);
    if (req > 5'(P_MAX_DATA_BITS))    return 5'(P_MAX_DATA_BITS);
    return req;
  endfunction

  function automatic logic [P_MAX_DATA_BITS-1:0] mask_data(
    input logic [P_MAX_DATA_BITS-1:0] d,
    input logic [4:0]                 n
  );
    logic [P_MAX_DATA_BITS-1:0] m;
    m = '0;
    for (int i = 0; i < P_MAX_DATA_BITS; i++) begin
      m[i] = d[i] & (i < int'(n));
    end
    return m;
  endfunction

  // Data is pre-masked, so the reduction covers exactly the active bits.
  function automatic logic parity_bit(
    input logic [P_MAX_DATA_BITS-1:0] d,
    input parity_e                    mode
  );
    case (mode)
      PAR_ODD:  return ~^d;
      PAR_EVEN: return ^d;
      default:  return 1'b1;
    endcase
  endfunction

  tx_state_e                  state_q, state_d;
  logic [P_MAX_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [4:0]                 bit_idx_q, bit_idx_d;
  logic [4:0]                 nbits_q, nbits_d;
  parity_e                    par_q, par_d;
  logic                       par_bit_q, par_bit_d;
  logic                       two_stop_q, two_stop_d;
  logic [P_DIV_WIDTH-1:0]     div_q, div_d;
  logic                       txd_q, txd_d;
  logic [P_CTS_SYNC_STAGES-1:0] cts_sync_q;

  logic                   cts_ok;
  logic                   handshake;
  logic                   cnt_load;
  logic [P_DIV_WIDTH-1:0] cnt_val;
  logic                   bit_end;

  uart_baud_cnt #(
    .P_DIV_WIDTH(P_DIV_WIDTH)
  ) u_baud_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .bit_end_o  (bit_end)
  );

  // CTS is asynchronous; the synchroniser resets to "not clear".
  always_ff @(posedge clock) begin
    if (!reset) begin
      cts_sync_q <= '1;
    end else begin
      cts_sync_q <= {cts_sync_q[P_CTS_SYNC_STAGES-2:0], CTS};
    end
  end

  assign cts_ok = ~cts_sync_q[P_CTS_SYNC_STAGES-1];

`ifdef UART_TX_BREAK_EN
  assign s_ready = (state_q == IDLE) && cts_ok && !cfg_break;
`else
  assign s_ready = (state_q == IDLE) && cts_ok;
`endif

  assign handshake = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    nbits_d    = nbits_q;
    par_d      = par_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    div_d      = div_q;
    cnt_load   = 1'b0;
    cnt_val    = div_q;
    frame_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (handshake) begin
          nbits_d    = clamp_bits(cfg_data_bits);
          shreg_d    = mask_data(s_data, nbits_d);
          par_d      = parity_e'(cfg_parity);
          par_bit_d  = parity_bit(shreg_d, par_d);
          two_stop_d = cfg_two_stop;
          div_d      = cfg_baud_div;
          bit_idx_d  = '0;
          cnt_load   = 1'b1;
          cnt_val    = cfg_baud_div;
          state_d    = START;
        end
`ifdef UART_TX_BREAK_EN
        else if (cfg_break) begin
          state_d = BREAK;
        end
`endif
      end

      START: begin
        if (bit_end) begin
          cnt_load = 1'b1;
          state_d  = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_load = 1'b1;
          if (bit_idx_q == nbits_q - 5'd1) begin
            state_d = (par_q == PAR_NONE) ? STOP1 : PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 5'd1;
            shreg_d   = shreg_q >> 1;
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          cnt_load = 1'b1;
          state_d  = STOP1;
        end
      end

      STOP1: begin
        if (bit_end) begin
          if (two_stop_q) begin
            cnt_load = 1'b1;
            state_d  = STOP2;
          end else begin
            frame_done = reset;
            state_d    = IDLE;
          end
        end
      end

      STOP2: begin
        if (bit_end) begin
          frame_done = reset;
          state_d    = IDLE;
        end
      end

`ifdef UART_TX_BREAK_EN
      // The mark after a break uses the divisor present at release time.
      BREAK: begin
        if (!cfg_break) begin
          cnt_load = 1'b1;
          cnt_val  = cfg_baud_div;
          state_d  = BREAK_MARK;
        end
      end

      BREAK_MARK: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // TxD is registered from the next state so the pin never glitches.
  always_comb begin
    txd_d = UART_IDLE_LEVEL;
    case (state_d)
      START:  txd_d = 1'b0;
      DATA:   txd_d = shreg_d[0];
      PARITY: txd_d = par_bit_d;
`ifdef UART_TX_BREAK_EN
      BREAK:  txd_d = 1'b0;
`endif
      default: txd_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      txd_q   <= UART_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
    end
  end

  always_ff @(posedge clock) begin
    shreg_q    <= shreg_d;
    bit_idx_q  <= bit_idx_d;
    nbits_q    <= nbits_d;
    par_q      <= par_d;
    par_bit_q  <= par_bit_d;
    two_stop_q <= two_stop_d;
    div_q      <= div_d;
  end

  always_comb begin
    busy = 1'b0;
    case (state_q)
      START, DATA, PARITY, STOP1, STOP2: busy = 1'b1;
      default:                           busy = 1'b0;
    endcase
  end

  assign TxD = txd_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: table of frame configurations with expected parity and
// length, scoreboard queue of expected waveforms, plus CTS/reset/back-to-back/break sequences.
`timescale 1ns/1ps
module tb_uart_tx_engine;

  localparam int MAXB = 8;
  localparam int DIVW = 16;
  localparam int SYNC = 2;

  typedef struct {
    logic [7:0] data;
    logic [4:0] dbits;
    logic [1:0] par;
    logic       two_stop;
    int         div;
    int         exp_n;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  typedef struct {
    logic [19:0] lvl;
    int          nb;
    int          div;
    int          len;
  } frame_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [DIVW-1:0] cfg_baud_div = '0;
  logic [4:0]      cfg_data_bits = 5'd8;
  logic [1:0]      cfg_parity = 2'b00;
  logic            cfg_two_stop = 1'b0;
`ifdef UART_TX_BREAK_EN
  logic            cfg_break = 1'b0;
`endif
  logic [MAXB-1:0] s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic            CTS = 1'b0;
  logic            TxD;
  logic            busy;
  logic            frame_done;

  int     n_tests = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     last_end = -100;
  int     frames_seen = 0;
  bit     mon_busy = 1'b0;
  frame_t exp_q[$];
  int     gaps[$];
  vec_t   vecs[7];

  uart_tx_engine #(
    .P_MAX_DATA_BITS  (MAXB),
    .P_DIV_WIDTH      (DIVW),
    .P_CTS_SYNC_STAGES(SYNC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_baud_div (cfg_baud_div),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity   (cfg_parity),
    .cfg_two_stop (cfg_two_stop),
`ifdef UART_TX_BREAK_EN
    .cfg_break    (cfg_break),
`endif
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .CTS          (CTS),
    .TxD          (TxD),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic frame_t make_frame(input vec_t v);
    frame_t f;
    f.lvl = '1;
    f.nb  = 0;
    f.lvl[f.nb] = 1'b0;
    f.nb++;
    for (int i = 0; i < v.exp_n; i++) begin
      f.lvl[f.nb] = v.data[i];
      f.nb++;
    end
    if (v.par != 2'b00) begin
      f.lvl[f.nb] = v.exp_par;
      f.nb++;
    end
    f.lvl[f.nb] = 1'b1;
    f.nb++;
    if (v.two_stop) begin
      f.lvl[f.nb] = 1'b1;
      f.nb++;
    end
    f.div = v.div;
    f.len = v.exp_len;
    return f;
  endfunction

  task automatic drive(input vec_t v);
    s_data        = v.data;
    cfg_data_bits = v.dbits;
    cfg_parity    = v.par;
    cfg_two_stop  = v.two_stop;
    cfg_baud_div  = DIVW'(v.div);
  endtask

  task automatic send(input vec_t v);
    int waited;
    waited = 0;
    @(negedge clock);
    drive(v);
    s_valid = 1'b1;
    while (!s_ready && waited < 500) begin
      @(negedge clock);
      waited++;
    end
    if (!s_ready) begin
      check("handshake_timeout", 0, 1);
      s_valid = 1'b0;
    end else begin
      exp_q.push_back(make_frame(v));
      @(posedge clock);
      #1 s_valid = 1'b0;
    end
  endtask

  task automatic wait_frames();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 5000) begin
      check("frame_timeout", 0, 1);
      exp_q.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  // Scoreboard consumer: checks each frame's level, bit timing, frame_done position and trailing idle.
  initial begin : monitor
    frame_t f;
    int     good, len, fd_at, fd_cnt;
    bit     abort;
    forever begin
      @(negedge clock);
      if (reset && busy && TxD == 1'b0) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          f = exp_q.pop_front();
          gaps.push_back(cyc - last_end - 1);
          abort  = 1'b0;
          len    = 0;
          fd_at  = 0;
          fd_cnt = 0;
          for (int b = 0; b < f.nb; b++) begin
            good = 0;
            for (int c = 0; c <= f.div; c++) begin
              if (b != 0 || c != 0) @(negedge clock);
              if (!reset) begin
                abort = 1'b1;
                break;
              end
              len++;
              if (busy && TxD == f.lvl[b]) good++;
              if (frame_done) begin
                fd_cnt++;
                fd_at = len;
              end
            end
            if (abort) break;
            check($sformatf("frame%0d_bit%0d_clocks", frames_seen, b), good, f.div + 1);
          end
          if (!abort) begin
            check($sformatf("frame%0d_done_at", frames_seen), fd_at, f.len);
            check($sformatf("frame%0d_done_count", frames_seen), fd_cnt, 1);
            last_end = cyc;
            frames_seen++;
            @(negedge clock);
            check("frame_idle_after", int'({busy, TxD, frame_done}), 3'b010);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t v;
    int   bad, lat, cnt;

    // data, dbits, parity, two_stop, div, exp_n, exp_par, exp_len
    vecs[0] = '{8'h55, 5'd8,  2'b00, 1'b0, 9, 8, 1'b0, 100};
    vecs[1] = '{8'hC1, 5'd7,  2'b10, 1'b1, 3, 7, 1'b0, 44};
    vecs[2] = '{8'h1F, 5'd5,  2'b01, 1'b0, 0, 5, 1'b0, 8};
    vecs[3] = '{8'hE6, 5'd3,  2'b00, 1'b0, 1, 5, 1'b0, 14};
    vecs[4] = '{8'h00, 5'd6,  2'b11, 1'b1, 2, 6, 1'b1, 30};
    vecs[5] = '{8'hA5, 5'd20, 2'b01, 1'b0, 1, 8, 1'b1, 22};
    vecs[6] = '{8'h07, 5'd8,  2'b10, 1'b1, 0, 8, 1'b1, 12};

    // Reset values
    repeat (3) @(negedge clock);
    check("reset_txd", int'(TxD), 1);
    check("reset_s_ready", int'(s_ready), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_done", int'(frame_done), 0);
    reset = 1'b1;
    @(negedge clock);
    check("cts_sync_not_clear_yet", int'(s_ready), 0);
    @(negedge clock);
    check("cts_sync_clear", int'(s_ready), 1);

    // Table of frame formats
    foreach (vecs[i]) begin
      send(vecs[i]);
      wait_frames();
    end
    check("table_frames", frames_seen, 7);

    // Three back-to-back 5O1 div=0 characters
    for (int k = 0; k < 3; k++) send(vecs[2]);
    wait_frames();
    check("b2b_gap_2", gaps[gaps.size()-2], 1);
    check("b2b_gap_3", gaps[gaps.size()-1], 1);

    // CTS flow control
    CTS = 1'b1;
    repeat (4) @(negedge clock);
    v = '{8'hA3, 5'd8, 2'b00, 1'b0, 1, 8, 1'b0, 20};
    drive(v);
    s_valid = 1'b1;
    exp_q.push_back(make_frame(v));
    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (s_ready || busy || !TxD) bad++;
    end
    check("cts_blocked_cycles", bad, 0);
    CTS = 1'b0;
    lat = 0;
    while (!busy && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("cts_start_latency", lat, SYNC + 1);
    s_valid = 1'b0;
    repeat (4) @(negedge clock);
    CTS = 1'b1;
    wait_frames();
    check("cts_ready_held_low", int'(s_ready), 0);
    CTS = 1'b0;
    repeat (4) @(negedge clock);

    // Reset during data bit 3
    v = '{8'h96, 5'd8, 2'b00, 1'b0, 3, 8, 1'b0, 40};
    send(v);
    repeat (18) @(negedge clock);
    check("busy_before_reset", int'(busy), 1);
    check("txd_bit3_before_reset", int'(TxD), 0);
    reset = 1'b0;
    @(negedge clock);
    check("reset_mid_txd", int'(TxD), 1);
    check("reset_mid_busy", int'(busy), 0);
    check("reset_mid_frame_done", int'(frame_done), 0);
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    cnt = frames_seen;
    send(v);
    wait_frames();
    check("frame_after_reset", frames_seen, cnt + 1);

    // Configuration changes mid-frame are ignored
    v = '{8'h3C, 5'd8, 2'b10, 1'b0, 2, 8, 1'b0, 33};
    send(v);
    cfg_parity    = 2'b01;
    cfg_data_bits = 5'd5;
    cfg_two_stop  = 1'b1;
    cfg_baud_div  = '0;
    wait_frames();

`ifdef UART_TX_BREAK_EN
    // Break: 50 clocks low, then div+1 clocks of mark before s_ready
    @(negedge clock);
    cfg_baud_div = DIVW'(4);
    cfg_break    = 1'b1;
    check("break_ready_low", int'(s_ready), 0);
    bad = 0;
    repeat (50) begin
      @(negedge clock);
      if (TxD !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("break_low_cycles", bad, 0);
    cfg_break = 1'b0;
    cnt = 0;
    bad = 0;
    while (!s_ready && cnt < 50) begin
      @(negedge clock);
      cnt++;
      if (TxD !== 1'b1) bad++;
    end
    check("break_mark_clocks", cnt - 1, 5);
    check("break_mark_level", bad, 0);
    send(vecs[0]);
    wait_frames();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
